// File: rtl/inference_sequencer.sv
// inference_sequencer: sequences one SNN inference per host request, from image launch to a latched classification.
module inference_sequencer #(
  parameter int IMAGE_SIZE = 526,
  parameter int IMAGE_SIZE_BITS = $clog2(IMAGE_SIZE),
  parameter int N_OUT = 10,
  parameter int N_OUT_BITS = $clog2(N_OUT),
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int TO_BITS = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     START,
  output logic                     BUSY,
  output logic                     NEW_IMAGE,
  input  logic                     IMAGE_ENCODED,
  input  logic                     AERIN_REQ,
  input  logic                     AERIN_ACK,
  input  logic                     OUT_SPIKE,
  input  logic [N_OUT_BITS-1:0]    OUT_SPIKE_ID,
  output logic                     INFERENCE_DONE,
  output logic                     RESULT_VALID,
  output logic [N_OUT_BITS-1:0]    RESULT_ID,
  output logic                     RESULT_TIMEOUT,
  output logic [IMAGE_SIZE_BITS:0] EVENT_COUNT
);
  typedef enum logic [2:0] {IDLE, LOAD, ENCODE, WAIT_OUT, DONE} state_t;
  localparam logic [N_OUT_BITS:0] N_OUT_V = N_OUT[N_OUT_BITS:0];
  localparam logic [TO_BITS-1:0] TO_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);
  state_t state;
  logic [TO_BITS-1:0] to_cnt;
  logic ack_d;
  logic spike;
  logic event_hit;
  assign spike = OUT_SPIKE && ({1'b0, OUT_SPIKE_ID} < N_OUT_V);
  assign event_hit = AERIN_REQ && AERIN_ACK && !ack_d && (state == ENCODE || state == WAIT_OUT);
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      state <= IDLE;
      BUSY <= 1'b0;
      NEW_IMAGE <= 1'b0;
      INFERENCE_DONE <= 1'b0;
      RESULT_VALID <= 1'b0;
      RESULT_ID <= '0;
      RESULT_TIMEOUT <= 1'b0;
      EVENT_COUNT <= '0;
      to_cnt <= '0;
      ack_d <= 1'b0;
    end else begin
      ack_d <= AERIN_ACK;
      NEW_IMAGE <= 1'b0;
      INFERENCE_DONE <= 1'b0;
      if (event_hit && !(&EVENT_COUNT)) EVENT_COUNT <= EVENT_COUNT + 1'b1;
      case (state)
        IDLE:
          if (START) begin
            state <= LOAD;
            BUSY <= 1'b1;
            NEW_IMAGE <= 1'b1;
            RESULT_VALID <= 1'b0;
            RESULT_TIMEOUT <= 1'b0;
            RESULT_ID <= '0;
            EVENT_COUNT <= '0;
          end
        LOAD: state <= ENCODE;
        ENCODE:
          if (spike) begin
            state <= DONE;
            INFERENCE_DONE <= 1'b1;
            RESULT_VALID <= 1'b1;
            RESULT_ID <= OUT_SPIKE_ID;
          end else if (IMAGE_ENCODED) begin
            state <= WAIT_OUT;
            to_cnt <= '0;
          end
        WAIT_OUT:
          if (spike || to_cnt == TO_LAST) begin
            state <= DONE;
            INFERENCE_DONE <= 1'b1;
            RESULT_VALID <= 1'b1;
            RESULT_ID <= spike ? OUT_SPIKE_ID : '0;
            RESULT_TIMEOUT <= !spike;
          end else to_cnt <= to_cnt + 1'b1;
        DONE: begin
          state <= IDLE;
          BUSY <= 1'b0;
        end
        default: begin
          state <= IDLE;
          BUSY <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_inference_sequencer.sv
// tb_inference_sequencer: randomized stimulus checked every cycle against a phase-level reference model.
module tb_inference_sequencer;
  localparam int N_OUT = 10;
  localparam int TIMEOUT = 4096;
  localparam int CNT_MAX = 2047;
  logic CLK = 1'b0;
  logic RST, START, IMAGE_ENCODED, AERIN_REQ, AERIN_ACK, OUT_SPIKE;
  logic [3:0] OUT_SPIKE_ID;
  logic BUSY, NEW_IMAGE, INFERENCE_DONE, RESULT_VALID, RESULT_TIMEOUT;
  logic [3:0] RESULT_ID;
  logic [10:0] EVENT_COUNT;
  inference_sequencer dut (
    .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .NEW_IMAGE(NEW_IMAGE),
    .IMAGE_ENCODED(IMAGE_ENCODED), .AERIN_REQ(AERIN_REQ), .AERIN_ACK(AERIN_ACK),
    .OUT_SPIKE(OUT_SPIKE), .OUT_SPIKE_ID(OUT_SPIKE_ID), .INFERENCE_DONE(INFERENCE_DONE),
    .RESULT_VALID(RESULT_VALID), .RESULT_ID(RESULT_ID), .RESULT_TIMEOUT(RESULT_TIMEOUT),
    .EVENT_COUNT(EVENT_COUNT)
  );
  always #5 CLK = ~CLK;
  int checks = 0;
  int failures = 0;
  bit chk_en = 0;
  // Reference model: 0 idle, 1 launching, 2 encoding, 3 awaiting output, 4 finishing
  int m_phase, m_waited, m_cnt, m_id;
  bit m_prev_ack, m_busy, m_new, m_done, m_valid, m_to;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_phase = 0; m_waited = 0; m_cnt = 0; m_id = 0;
    m_prev_ack = 0; m_busy = 0; m_new = 0; m_done = 0; m_valid = 0; m_to = 0;
  endtask
  task automatic finish_inf(input int id, input bit to);
    m_phase = 4; m_done = 1; m_valid = 1; m_id = id; m_to = to;
  endtask
  task automatic model_step();
    bit ev, sp;
    ev = AERIN_REQ && AERIN_ACK && !m_prev_ack;
    sp = OUT_SPIKE && (int'(OUT_SPIKE_ID) < N_OUT);
    m_prev_ack = AERIN_ACK;
    m_new = 0;
    m_done = 0;
    if (m_phase == 0) begin
      if (START) begin
        m_phase = 1; m_new = 1; m_valid = 0; m_to = 0; m_id = 0; m_cnt = 0;
      end
    end else if (m_phase == 1) m_phase = 2;
    else if (m_phase == 4) m_phase = 0;
    else begin
      if (ev && m_cnt < CNT_MAX) m_cnt++;
      if (sp) finish_inf(int'(OUT_SPIKE_ID), 0);
      else if (m_phase == 2) begin
        if (IMAGE_ENCODED) begin m_phase = 3; m_waited = 0; end
      end else begin
        m_waited++;
        if (m_waited == TIMEOUT) finish_inf(0, 1);
      end
    end
    m_busy = (m_phase != 0);
  endtask
  task automatic tick();
    @(posedge CLK);
    if (RST) model_reset(); else model_step();
    #1;
  endtask
  always @(negedge CLK)
    if (chk_en) begin
      chk("busy", BUSY, m_busy);
      chk("new_image", NEW_IMAGE, m_new);
      chk("inference_done", INFERENCE_DONE, m_done);
      chk("result_valid", RESULT_VALID, m_valid);
      chk("result_id", RESULT_ID, m_id);
      chk("result_timeout", RESULT_TIMEOUT, m_to);
      chk("event_count", EVENT_COUNT, m_cnt);
    end
  task automatic noise();
    OUT_SPIKE = ($urandom_range(0, 9) == 0);
    OUT_SPIKE_ID = 4'($urandom_range(N_OUT, 15));
  endtask
  task automatic handshakes(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        AERIN_ACK = 1; tick(); AERIN_ACK = 0; tick();
      end
      AERIN_REQ = 1; noise(); tick();
      AERIN_ACK = 1; noise(); tick();
      AERIN_REQ = 0; AERIN_ACK = 0; OUT_SPIKE = 0; tick();
      repeat ($urandom_range(0, 1)) tick();
    end
  endtask
  task automatic start_inf();
    START = 1; tick(); START = 0;
    chk("launch_new_image", NEW_IMAGE, 1);
    chk("launch_busy", BUSY, 1);
    tick();
    chk("launch_pulse_end", NEW_IMAGE, 0);
  endtask
  task automatic spike(input int id);
    OUT_SPIKE = 1; OUT_SPIKE_ID = 4'(id); tick(); OUT_SPIKE = 0;
  endtask
  task automatic enter_wait();
    IMAGE_ENCODED = 1; tick(); IMAGE_ENCODED = 0;
  endtask
  task automatic wait_done(input int budget, output int n);
    n = 0;
    while (!INFERENCE_DONE && n < budget) begin tick(); n++; end
    chk("done_seen", INFERENCE_DONE, 1);
  endtask
  initial begin
    int n, ev, id, mode;
    RST = 1; START = 0; IMAGE_ENCODED = 0; AERIN_REQ = 0; AERIN_ACK = 0;
    OUT_SPIKE = 0; OUT_SPIKE_ID = 0;
    model_reset();
    chk_en = 1;
    repeat (3) tick();
    RST = 0;
    chk("rst_busy", BUSY, 0);
    chk("rst_valid", RESULT_VALID, 0);
    chk("rst_count", EVENT_COUNT, 0);
    tick();
    start_inf();
    handshakes(526);
    enter_wait();
    repeat (100) tick();
    spike(7);
    chk("full_done", INFERENCE_DONE, 1);
    chk("full_valid", RESULT_VALID, 1);
    chk("full_id", RESULT_ID, 7);
    chk("full_timeout", RESULT_TIMEOUT, 0);
    chk("full_count", EVENT_COUNT, 526);
    tick();
    chk("full_done_pulse", INFERENCE_DONE, 0);
    start_inf();
    handshakes(40);
    spike(3);
    chk("early_done", INFERENCE_DONE, 1);
    chk("early_id", RESULT_ID, 3);
    chk("early_count", EVENT_COUNT, 40);
    tick();
    IMAGE_ENCODED = 1; tick(); IMAGE_ENCODED = 0;
    chk("late_encoded_idle", BUSY, 0);
    tick();
    start_inf();
    enter_wait();
    wait_done(5000, n);
    chk("timeout_latency", n, TIMEOUT);
    chk("timeout_flag", RESULT_TIMEOUT, 1);
    chk("timeout_id", RESULT_ID, 0);
    tick();
    start_inf();
    enter_wait();
    repeat (TIMEOUT - 1) tick();
    chk("expiry_not_yet", INFERENCE_DONE, 0);
    spike(2);
    chk("expiry_spike_done", INFERENCE_DONE, 1);
    chk("expiry_spike_id", RESULT_ID, 2);
    chk("expiry_spike_to", RESULT_TIMEOUT, 0);
    tick();
    start_inf();
    enter_wait();
    repeat (5) tick();
    spike(12);
    tick();
    chk("invalid_ignored", INFERENCE_DONE, 0);
    chk("invalid_busy", BUSY, 1);
    spike(5);
    chk("valid_after_invalid", RESULT_ID, 5);
    tick();
    start_inf();
    IMAGE_ENCODED = 1; OUT_SPIKE = 1; OUT_SPIKE_ID = 1; tick();
    IMAGE_ENCODED = 0; OUT_SPIKE = 0;
    chk("tie_done", INFERENCE_DONE, 1);
    chk("tie_id", RESULT_ID, 1);
    chk("tie_timeout", RESULT_TIMEOUT, 0);
    tick();
    START = 1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!NEW_IMAGE && n < 8) begin tick(); n++; end
      chk("b2b_new_image", NEW_IMAGE, 1);
      chk("b2b_valid_cleared", RESULT_VALID, 0);
      tick();
      ev = $urandom_range(3, 12);
      handshakes(ev);
      id = $urandom_range(0, N_OUT - 1);
      spike(id);
      chk("b2b_id", RESULT_ID, id);
      chk("b2b_count", EVENT_COUNT, ev);
    end
    START = 0;
    repeat (3) tick();
    for (int k = 0; k < 8; k++) begin
      start_inf();
      mode = $urandom_range(0, 2);
      handshakes($urandom_range(0, 30));
      if (mode == 0) spike($urandom_range(0, N_OUT - 1));
      else if (mode == 1) begin
        enter_wait();
        for (int j = $urandom_range(0, 200); j > 0; j--) begin noise(); tick(); end
        spike($urandom_range(0, N_OUT - 1));
      end else begin
        IMAGE_ENCODED = 1; tick(); IMAGE_ENCODED = 0;
        handshakes($urandom_range(0, 5));
        spike($urandom_range(0, N_OUT - 1));
      end
      wait_done(2, n);
      repeat ($urandom_range(1, 3)) tick();
    end
    start_inf();
    handshakes(4);
    enter_wait();
    repeat (20) tick();
    #2 RST = 1;
    model_reset();
    #1;
    chk("async_busy", BUSY, 0);
    chk("async_new", NEW_IMAGE, 0);
    chk("async_done", INFERENCE_DONE, 0);
    chk("async_valid", RESULT_VALID, 0);
    chk("async_id", RESULT_ID, 0);
    chk("async_to", RESULT_TIMEOUT, 0);
    chk("async_count", EVENT_COUNT, 0);
    tick();
    RST = 0;
    tick();
    start_inf();
    spike(4);
    chk("post_reset_id", RESULT_ID, 4);
    repeat (2) tick();
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/inference_sequencer.md
Name: inference_sequencer

Overview:
- Top-level controller that sequences one SNN inference per host request.
- Launches an image into the encoder with NEW_IMAGE.
- Monitors the encoder-to-core AER link and counts delivered events.
- Waits for the first output-layer spike or a timeout, then terminates the inference with INFERENCE_DONE and reports a latched classification result.

Parameters:
- IMAGE_SIZE, 526, pixels per image. This is the maximum number of AER events per inference.
- IMAGE_SIZE_BITS, $clog2(IMAGE_SIZE), index width.
- N_OUT, 10, number of output-layer neurons (classes).
- N_OUT_BITS, $clog2(N_OUT), class ID width.
- TIMEOUT_CYCLES, 4096, maximum cycles to wait for an output spike after IMAGE_ENCODED.
- TO_BITS, $clog2(TIMEOUT_CYCLES+1), timeout counter width.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- START  in  1  host level request; sampled only in IDLE.
- BUSY  out  1  high in every state except IDLE.
- NEW_IMAGE  out  1  one-cycle pulse to the encoder; the image must be stable on the bus.
- IMAGE_ENCODED  in  1  encoder reports that all pixels have been sent.
- AERIN_REQ  in  1  monitored copy of the encoder AER request.
- AERIN_ACK  in  1  monitored copy of the core AER acknowledge.
- OUT_SPIKE  in  1  one-cycle valid from the output layer.
- OUT_SPIKE_ID  in  N_OUT_BITS  ID of the spiking output neuron.
- INFERENCE_DONE  out  1  one-cycle pulse to the encoder and the core; aborts or ends the inference.
- RESULT_VALID  out  1  result fields are valid; held high until the next accepted START.
- RESULT_ID  out  N_OUT_BITS  winning class ID.
- RESULT_TIMEOUT  out  1  inference ended by timeout; RESULT_ID is 0 in that case.
- EVENT_COUNT  out  IMAGE_SIZE_BITS+1  number of AER events accepted during the last inference.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. All outputs 0: BUSY, NEW_IMAGE, INFERENCE_DONE, RESULT_VALID, RESULT_ID, RESULT_TIMEOUT, EVENT_COUNT. Internal timeout counter = 0.
- States: IDLE, LOAD, ENCODE, WAIT_OUT, DONE.
- IDLE:
  - When START=1, go to LOAD.
  - On that transition, clear RESULT_VALID, RESULT_TIMEOUT, RESULT_ID and EVENT_COUNT.
- LOAD (exactly 1 cycle):
  - NEW_IMAGE=1 for this cycle only, then go to ENCODE.
  - NEW_IMAGE is registered. It is high in the cycle after START is sampled.
- ENCODE:
  - If OUT_SPIKE=1 with OUT_SPIKE_ID<N_OUT: latch the ID and go to DONE. This is early termination; the encoder is aborted by INFERENCE_DONE.
  - Otherwise, if IMAGE_ENCODED=1: clear the timeout counter and go to WAIT_OUT.
  - If both occur in the same cycle, the spike wins.
- WAIT_OUT:
  - The timeout counter increments every cycle.
  - If a valid OUT_SPIKE arrives, latch the ID and go to DONE.
  - Otherwise, when the counter reaches TIMEOUT_CYCLES-1, set RESULT_TIMEOUT=1, set RESULT_ID=0 and go to DONE.
  - If a spike arrives on the same cycle the timeout expires, the spike wins and RESULT_TIMEOUT=0.
- Invalid spikes: OUT_SPIKE with OUT_SPIKE_ID>=N_OUT is ignored in all states. OUT_SPIKE in IDLE, LOAD or DONE is ignored.
- DONE (exactly 1 cycle):
  - INFERENCE_DONE=1 and RESULT_VALID is set, then go to IDLE.
  - START still high in DONE is not acted on. A new inference begins no earlier than the IDLE cycle after DONE.
- Event counting:
  - Detect the rising edge of AERIN_ACK (registered previous value) while AERIN_REQ=1.
  - Counts only in ENCODE and WAIT_OUT.
  - Saturates at all-ones and does not wrap.
  - EVENT_COUNT is live during the inference and frozen from DONE until the next accepted START.
  - A full unaborted image yields exactly IMAGE_SIZE events.
- BUSY is a registered decode of state!=IDLE. It rises in the same cycle as NEW_IMAGE.
- Latency: START sampled at cycle 0 → NEW_IMAGE at cycle 1 → earliest INFERENCE_DONE at cycle 3 (a spike in the first ENCODE cycle, cycle 2).

Test Plan:
- Reset then START=1: NEW_IMAGE high for exactly 1 cycle, BUSY=1. Drive 526 REQ/ACK handshakes, then IMAGE_ENCODED, then OUT_SPIKE ID=7 after 100 cycles → one-cycle INFERENCE_DONE, RESULT_VALID=1, RESULT_ID=7, RESULT_TIMEOUT=0, EVENT_COUNT=526.
- OUT_SPIKE ID=3 after 40 handshakes, before IMAGE_ENCODED → INFERENCE_DONE the following cycle, RESULT_ID=3, EVENT_COUNT=40, later IMAGE_ENCODED ignored.
- IMAGE_ENCODED, no spike → INFERENCE_DONE exactly 4096 cycles after entering WAIT_OUT, RESULT_TIMEOUT=1, RESULT_ID=0. Repeat with spike ID=2 on the expiry cycle → RESULT_ID=2, RESULT_TIMEOUT=0.
- OUT_SPIKE ID=12 (≥N_OUT) during WAIT_OUT, then ID=5 → RESULT_ID=5. Same-cycle IMAGE_ENCODED+spike ID=1 in ENCODE → DONE with RESULT_ID=1.
- START held high continuously → back-to-back inferences, exactly one NEW_IMAGE per inference. RESULT_VALID drops the cycle after IDLE re-accepts START. Each inference's EVENT_COUNT starts from 0.
- Assert RST mid-WAIT_OUT (asynchronously, between clock edges) → all outputs 0 immediately, state IDLE. START afterwards → normal NEW_IMAGE pulse.
